// File: rtl/host_mem_loader_pkg.sv
// Shared widths, FIFO depth and FSM encoding for the host memory loader.
package host_mem_loader_pkg;

  localparam int HML_MEM_W        = 16;
  localparam int HML_INS_W        = 12;
  localparam int HML_IMEMADDRW    = 6;
  localparam int HML_DMEMCSW      = 2;
  localparam int HML_SUBDMEMADDRW = 6;
  localparam int HML_FIFO_DEPTH   = 3;
  // Cycles from a read on the memory port to its data being pushed.
  localparam int HML_RD_STAGES    = 1;

  localparam logic HML_TGT_DM = 1'b0;
  localparam logic HML_TGT_IM = 1'b1;

  typedef enum logic [1:0] {
    HML_IDLE  = 2'd0,
    HML_WR    = 2'd1,
    HML_RD    = 2'd2,
    HML_DRAIN = 2'd3
  } hml_state_e;

endpackage

// File: rtl/hml_rd_fifo.sv
// Small synchronous read-return FIFO with occupancy count; head is registered storage.
module hml_rd_fifo
  import host_mem_loader_pkg::*;
#(
  parameter  int W     = HML_MEM_W,
  parameter  int DEPTH = HML_FIFO_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdat,
  input  logic          pop,
  output logic [W-1:0]  rdat,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdat    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/host_mem_loader.sv
// Host burst engine for the ASIP instruction SRAM and data memory; owns the
// memory ports (t_cs=0) only while a burst is in progress.
module host_mem_loader
  import host_mem_loader_pkg::*;
#(
  parameter int MW  = HML_MEM_W,
  parameter int IW  = HML_INS_W,
  parameter int IAW = HML_IMEMADDRW,
  parameter int CSW = HML_DMEMCSW,
  parameter int SAW = HML_SUBDMEMADDRW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               h_cmd_valid,
  output logic               h_cmd_ready,
  input  logic               h_cmd_wr,
  input  logic               h_cmd_tgt,
  input  logic [CSW+SAW-1:0] h_cmd_addr,
  input  logic [7:0]         h_cmd_len,
  input  logic               h_wdat_valid,
  output logic               h_wdat_ready,
  input  logic [MW-1:0]      h_wdat,
  output logic               h_rdat_valid,
  input  logic               h_rdat_ready,
  output logic [MW-1:0]      h_rdat,
  output logic               h_busy,
  output logic               h_done,
  output logic               t_cs,
  output logic               im_en_b,
  output logic               im_we_b,
  output logic [IAW-1:0]     im_addr,
  output logic [IW-1:0]      im_wdat,
  input  logic [IW-1:0]      im_rdat,
  output logic               dm_rw,
  output logic               dm_en_b,
  output logic [CSW-1:0]     dm_cs,
  output logic [SAW-1:0]     dm_addr,
  output logic [MW-1:0]      dm_wdat,
  input  logic [MW-1:0]      dm_rdat
);

  localparam int AW = CSW + SAW;
  localparam int CW = $clog2(HML_FIFO_DEPTH + 1);

  hml_state_e           state_q, state_d;
  logic                 tgt_q, tgt_d, acc_tgt;
  logic [AW-1:0]        addr_q, addr_d, acc_addr;
  logic [7:0]           rem_q, rem_d;
  logic [HML_RD_STAGES:0] vld_pipe;
  logic                 issue_rd, issue_wr, done_wr_q, done_rd;
  logic                 rd_pop, fifo_empty, inflight, rd_room;
  logic [CW-1:0]        fifo_cnt;
  logic [2:0]           rd_occ;
  logic [MW-1:0]        rd_word;

  assign t_cs         = (state_q == HML_IDLE);
  assign h_busy       = !t_cs;
  assign h_done       = done_wr_q | done_rd;
  assign h_rdat_valid = !fifo_empty;
  assign rd_pop       = h_rdat_valid && h_rdat_ready;
  assign inflight     = |vld_pipe;
  assign rd_word      = (tgt_q == HML_TGT_IM) ? MW'(im_rdat) : dm_rdat;

  // Reads already committed (queued or in the memory pipe), net of this
  // cycle's pop; one more issue is safe while this is at most 2.
  always_comb begin
    rd_occ = 3'(fifo_cnt) - 3'(rd_pop);
    for (int i = 0; i <= HML_RD_STAGES; i++) rd_occ = rd_occ + 3'(vld_pipe[i]);
  end
  assign rd_room = (rd_occ <= 3'd2);

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    acc_tgt      = tgt_q;
    acc_addr     = addr_q;
    issue_rd     = 1'b0;
    issue_wr     = 1'b0;
    done_rd      = 1'b0;
    h_cmd_ready  = 1'b0;
    h_wdat_ready = 1'b0;
    case (state_q)
      HML_IDLE: begin
        h_cmd_ready = 1'b1;
        if (h_cmd_valid) begin
          tgt_d    = h_cmd_tgt;
          acc_tgt  = h_cmd_tgt;
          acc_addr = h_cmd_addr;
          if (h_cmd_wr) begin
            addr_d  = h_cmd_addr;
            rem_d   = h_cmd_len;
            state_d = HML_WR;
          end else begin
            // First read goes out on the accept edge to save a cycle of latency.
            issue_rd = 1'b1;
            addr_d   = h_cmd_addr + 1'b1;
            rem_d    = h_cmd_len - 8'd1;
            state_d  = (h_cmd_len == 8'd0) ? HML_DRAIN : HML_RD;
          end
        end
      end
      HML_WR: begin
        h_wdat_ready = 1'b1;
        if (h_wdat_valid) begin
          issue_wr = 1'b1;
          addr_d   = addr_q + 1'b1;
          rem_d    = rem_q - 8'd1;
          if (rem_q == 8'd0) state_d = HML_DRAIN;
        end
      end
      HML_RD: begin
        if (rd_room) begin
          issue_rd = 1'b1;
          addr_d   = addr_q + 1'b1;
          rem_d    = rem_q - 8'd1;
          if (rem_q == 8'd0) state_d = HML_DRAIN;
        end
      end
      HML_DRAIN: begin
        // Writes pass through here for one cycle so the final write sees t_cs=0.
        if (!inflight && (fifo_empty || (fifo_cnt == CW'(1) && rd_pop))) begin
          state_d = HML_IDLE;
          done_rd = !fifo_empty;
        end
      end
      default: state_d = HML_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HML_IDLE;
      tgt_q     <= HML_TGT_DM;
      addr_q    <= '0;
      rem_q     <= '0;
      vld_pipe  <= '0;
      done_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      vld_pipe  <= {vld_pipe[HML_RD_STAGES-1:0], issue_rd};
      done_wr_q <= issue_wr && (rem_q == 8'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_en_b <= 1'b1;
      im_we_b <= 1'b1;
      im_addr <= '0;
      im_wdat <= '0;
      dm_en_b <= 1'b1;
      dm_rw   <= 1'b1;
      dm_cs   <= '0;
      dm_addr <= '0;
      dm_wdat <= '0;
    end else begin
      im_en_b <= 1'b1;
      im_we_b <= 1'b1;
      dm_en_b <= 1'b1;
      dm_rw   <= 1'b1;
      if (issue_rd || issue_wr) begin
        if (acc_tgt == HML_TGT_IM) begin
          im_en_b <= 1'b0;
          im_we_b <= !issue_wr;
          im_addr <= acc_addr[IAW-1:0];
          if (issue_wr) im_wdat <= h_wdat[IW-1:0];
        end else begin
          dm_en_b <= 1'b0;
          dm_rw   <= !issue_wr;
          dm_cs   <= acc_addr[AW-1:SAW];
          dm_addr <= acc_addr[SAW-1:0];
          if (issue_wr) dm_wdat <= h_wdat;
        end
      end
    end
  end

  hml_rd_fifo #(.W(MW), .DEPTH(HML_FIFO_DEPTH)) u_rd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_pipe[HML_RD_STAGES]),
    .wdat  (rd_word),
    .pop   (rd_pop),
    .rdat  (h_rdat),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

endmodule
